// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the mem stage.
// Grants one requester in IDLE, then runs a single address/response transaction for it.
module mem_bus_arbiter #(
   parameter int unsigned ADDR_W          = 32,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,

   input  logic                data_req,
   input  logic                data_wr,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,

   output logic                bus_req,
   output logic                bus_wr,
   output logic [DATA_W/8-1:0] bus_wstrb,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_addr_ok,
   input  logic                bus_data_ok,
   input  logic [DATA_W-1:0]   bus_rdata,

   output logic                busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

   logic [1:0]          stateQ, stateD;
   logic                ownerQ, ownerD;
   logic [ADDR_W-1:0]   addrQ, addrD;
   logic                wrQ, wrD;
   logic [DATA_W/8-1:0] wstrbQ, wstrbD;
   logic [DATA_W-1:0]   wdataQ, wdataD;
   logic [3:0]          streakQ, streakD;

   logic grantData;
   logic grantInst;

   // Data normally wins; a waiting fetch is forced through once the streak saturates.
   always_comb begin
      grantData = 1'b0;
      grantInst = 1'b0;
      if (stateQ == IDLE) begin
         grantData = data_req && !(inst_req && (streakQ == STREAK_MAX));
         grantInst = inst_req && !grantData;
      end
   end

   always_comb begin
      stateD  = stateQ;
      ownerD  = ownerQ;
      addrD   = addrQ;
      wrD     = wrQ;
      wstrbD  = wstrbQ;
      wdataD  = wdataQ;
      streakD = streakQ;
      case (stateQ)
         IDLE: begin
            if (grantData) begin
               stateD = ADDR;
               ownerD = OWNER_DATA;
               addrD  = data_addr;
               wrD    = data_wr;
               wstrbD = data_wstrb;
               wdataD = data_wdata;
               if (inst_req) begin
                  streakD = (streakQ == STREAK_MAX) ? STREAK_MAX : streakQ + 4'd1;
               end else begin
                  streakD = '0;
               end
            end else if (grantInst) begin
               stateD  = ADDR;
               ownerD  = OWNER_INST;
               addrD   = inst_addr;
               wrD     = 1'b0;
               wstrbD  = '0;
               wdataD  = '0;
               streakD = '0;
            end
         end
         ADDR: begin
            if (bus_addr_ok) begin
               stateD = RESP;
            end
         end
         RESP: begin
            if (bus_data_ok) begin
               stateD = IDLE;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ  <= IDLE;
         ownerQ  <= OWNER_INST;
         addrQ   <= '0;
         wrQ     <= 1'b0;
         wstrbQ  <= '0;
         wdataQ  <= '0;
         streakQ <= '0;
      end else begin
         stateQ  <= stateD;
         ownerQ  <= ownerD;
         addrQ   <= addrD;
         wrQ     <= wrD;
         wstrbQ  <= wstrbD;
         wdataQ  <= wdataD;
         streakQ <= streakD;
      end
   end

   assign inst_addr_ok = grantInst;
   assign data_addr_ok = grantData;

   // Responses outside RESP (stray or left over from an abandoned transaction) are dropped.
   assign inst_data_ok = (stateQ == RESP) && bus_data_ok && (ownerQ == OWNER_INST);
   assign data_data_ok = (stateQ == RESP) && bus_data_ok && (ownerQ == OWNER_DATA);

   assign inst_rdata = bus_rdata;
   assign data_rdata = bus_rdata;

   assign bus_req   = (stateQ == ADDR);
   assign bus_wr    = wrQ;
   assign bus_wstrb = wstrbQ;
   assign bus_addr  = addrQ;
   assign bus_wdata = wdataQ;

   assign busy = (stateQ != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stimulus pushes expected grants/responses into
// queues, and a negedge monitor pops and compares whenever the DUT raises addr_ok/data_ok.
module tb_mem_bus_arbiter;

   typedef struct packed {
      logic        isData;
      logic [31:0] rdata;
   } respT;

   logic        clk;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        bus_req;
   logic        bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;
   logic        busy;

   int checks;
   int failures;
   int monChecks;
   int monFails;

   logic grantQ[$];
   respT respQ[$];

   mem_bus_arbiter #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .MAX_DATA_STREAK(2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok),
      .inst_rdata  (inst_rdata),
      .data_req    (data_req),
      .data_wr     (data_wr),
      .data_wstrb  (data_wstrb),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok),
      .data_rdata  (data_rdata),
      .bus_req     (bus_req),
      .bus_wr      (bus_wr),
      .bus_wstrb   (bus_wstrb),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_addr_ok (bus_addr_ok),
      .bus_data_ok (bus_data_ok),
      .bus_rdata   (bus_rdata),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every grant and every response must match the next queued expectation.
   always @(negedge clk) begin
      if (inst_addr_ok || data_addr_ok) begin
         monChecks++;
         if (inst_addr_ok && data_addr_ok) begin
            monFails++;
            $display("FAIL grant: both addr_ok high, required exactly one");
         end else if (grantQ.size() == 0) begin
            monFails++;
            $display("FAIL grant: unexpected addr_ok (inst=%0b data=%0b), required none",
                     inst_addr_ok, data_addr_ok);
         end else begin
            logic expData;
            expData = grantQ.pop_front();
            if (data_addr_ok !== expData) begin
               monFails++;
               $display("FAIL grant order: got data=%0b required data=%0b at %0t",
                        data_addr_ok, expData, $time);
            end
         end
      end
      if (inst_data_ok || data_data_ok) begin
         monChecks++;
         if (inst_data_ok && data_data_ok) begin
            monFails++;
            $display("FAIL resp: both data_ok high, required exactly one");
         end else if (respQ.size() == 0) begin
            monFails++;
            $display("FAIL resp: unexpected data_ok (inst=%0b data=%0b), required none",
                     inst_data_ok, data_data_ok);
         end else begin
            respT exp;
            logic [31:0] actRdata;
            exp = respQ.pop_front();
            actRdata = data_data_ok ? data_rdata : inst_rdata;
            if (data_data_ok !== exp.isData || actRdata !== exp.rdata) begin
               monFails++;
               $display("FAIL resp: got data=%0b rdata=0x%08h required data=%0b rdata=0x%08h",
                        data_data_ok, actRdata, exp.isData, exp.rdata);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      logic respPend;
      logic dropReqs;
      int   nResp;
      int   nGrant;
      logic [1:0] order [6];

      checks = 0; failures = 0; monChecks = 0; monFails = 0;
      rst = 1'b1;
      inst_req = 1'b0; inst_addr = '0;
      data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h1234_5678;

      // Reset state
      @(posedge clk);
      #2;
      chk("reset busy", busy, 0);
      chk("reset bus_req", bus_req, 0);
      chk("reset bus_addr", bus_addr, 0);
      chk("reset bus_wr", bus_wr, 0);
      chk("reset inst_rdata mirror", inst_rdata, 32'h1234_5678);
      chk("reset data_rdata mirror", data_rdata, 32'h1234_5678);
      nextCycle();
      rst = 1'b0;
      bus_rdata = '0;

      // Single fetch
      nextCycle();
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000; grantQ.push_back(1'b0);
      sample();
      chk("fetch addr_ok T0", inst_addr_ok, 1);
      chk("fetch busy T0", busy, 0);
      nextCycle();
      inst_req = 1'b0; inst_addr = '0; bus_addr_ok = 1'b1;
      sample();
      chk("fetch bus_req T1", bus_req, 1);
      chk("fetch bus_addr T1", bus_addr, 32'hBFC0_0000);
      chk("fetch bus_wr T1", bus_wr, 0);
      chk("fetch busy T1", busy, 1);
      nextCycle();
      bus_addr_ok = 1'b0;
      sample();
      chk("fetch bus_req T2", bus_req, 0);
      chk("fetch data_ok T2", inst_data_ok, 0);
      nextCycle();
      bus_data_ok = 1'b1; bus_rdata = 32'h2401_0001;
      respQ.push_back('{isData: 1'b0, rdata: 32'h2401_0001});
      sample();
      chk("fetch data_ok T3", inst_data_ok, 1);
      chk("fetch rdata T3", inst_rdata, 32'h2401_0001);
      nextCycle();
      bus_data_ok = 1'b0;
      sample();
      chk("fetch data_ok T4", inst_data_ok, 0);
      chk("fetch busy T4", busy, 0);

      // Simultaneous requests: data first, fetch right after data_data_ok
      nextCycle();
      inst_req = 1'b1; inst_addr = 32'h0040_0000;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0010;
      grantQ.push_back(1'b1); grantQ.push_back(1'b0);
      sample();
      chk("simul data_addr_ok", data_addr_ok, 1);
      nextCycle();
      data_req = 1'b0; data_addr = '0; bus_addr_ok = 1'b1;
      sample();
      chk("simul bus_addr data", bus_addr, 32'h8000_0010);
      chk("simul inst stalled ADDR", inst_addr_ok, 0);
      nextCycle();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
      respQ.push_back('{isData: 1'b1, rdata: 32'h1111_1111});
      sample();
      chk("simul inst stalled RESP", inst_addr_ok, 0);
      nextCycle();
      bus_data_ok = 1'b0;
      sample();
      chk("simul inst_addr_ok", inst_addr_ok, 1);
      nextCycle();
      inst_req = 1'b0; bus_addr_ok = 1'b1;
      sample();
      chk("simul bus_addr inst", bus_addr, 32'h0040_0000);
      nextCycle();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2222_2222;
      respQ.push_back('{isData: 1'b0, rdata: 32'h2222_2222});
      sample();
      nextCycle();
      bus_data_ok = 1'b0;

      // Starvation with streak limit 2: D, D, I, D, D, I
      order[0] = 2'd1; order[1] = 2'd1; order[2] = 2'd0;
      order[3] = 2'd1; order[4] = 2'd1; order[5] = 2'd0;
      for (int k = 0; k < 6; k++) begin
         grantQ.push_back(order[k][0]);
         respQ.push_back('{isData: order[k][0], rdata: 32'hA000_0000 + 32'(k)});
      end
      inst_req = 1'b1; inst_addr = 32'hBFC0_0040;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0100;
      respPend = 1'b0; dropReqs = 1'b0; nResp = 0; nGrant = 0;
      for (int c = 0; c < 20; c++) begin
         if (dropReqs) begin
            inst_req = 1'b0; data_req = 1'b0;
         end
         bus_addr_ok = 1'b1;
         bus_data_ok = respPend;
         bus_rdata = respPend ? 32'hA000_0000 + 32'(nResp) : 32'h0;
         sample();
         if (bus_data_ok) nResp++;
         respPend = bus_req;
         if (inst_addr_ok || data_addr_ok) nGrant++;
         if (nGrant == 6) dropReqs = 1'b1;
         nextCycle();
      end
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      chk("starve responses", nResp, 6);
      chk("starve busy end", busy, 0);

      // Store with bus stalled three cycles
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
      data_addr = 32'h8000_1004; data_wdata = 32'hDEAD_BEEF;
      grantQ.push_back(1'b1);
      sample();
      chk("store addr_ok", data_addr_ok, 1);
      for (int c = 0; c < 4; c++) begin
         nextCycle();
         data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'hF;
         data_addr = '0; data_wdata = 32'hFFFF_FFFF;
         bus_addr_ok = (c == 3);
         sample();
         chk("store bus_req", bus_req, 1);
         chk("store bus_wr", bus_wr, 1);
         chk("store bus_addr", bus_addr, 32'h8000_1004);
         chk("store bus_wdata", bus_wdata, 32'hDEAD_BEEF);
         chk("store bus_wstrb", bus_wstrb, 4'b0011);
      end
      nextCycle();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5A5A_5A5A;
      respQ.push_back('{isData: 1'b1, rdata: 32'h5A5A_5A5A});
      sample();
      chk("store data_data_ok", data_data_ok, 1);
      chk("store bus_req RESP", bus_req, 0);
      nextCycle();
      bus_data_ok = 1'b0;

      // Stray responses in IDLE and ADDR
      nextCycle();
      bus_data_ok = 1'b1; bus_rdata = 32'h0BAD_0001;
      sample();
      chk("stray idle busy", busy, 0);
      chk("stray idle inst_data_ok", inst_data_ok, 0);
      chk("stray idle data_data_ok", data_data_ok, 0);
      nextCycle();
      bus_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
      grantQ.push_back(1'b0);
      sample();
      nextCycle();
      inst_req = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0BAD_0002;
      sample();
      chk("stray addr bus_req", bus_req, 1);
      chk("stray addr inst_data_ok", inst_data_ok, 0);
      nextCycle();
      bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
      sample();
      chk("stray addr still ADDR", bus_req, 1);
      nextCycle();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3333_3333;
      respQ.push_back('{isData: 1'b0, rdata: 32'h3333_3333});
      sample();
      chk("stray final inst_data_ok", inst_data_ok, 1);
      nextCycle();
      bus_data_ok = 1'b0;
      sample();
      chk("stray final busy", busy, 0);

      // Reset while in RESP
      nextCycle();
      inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
      grantQ.push_back(1'b0);
      nextCycle();
      inst_req = 1'b0; bus_addr_ok = 1'b1;
      nextCycle();
      bus_addr_ok = 1'b0;
      chk("rstresp busy before", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rstresp busy async", busy, 0);
      chk("rstresp bus_req async", bus_req, 0);
      nextCycle();
      rst = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0BAD_0003;
      sample();
      chk("rstresp late inst_data_ok", inst_data_ok, 0);
      chk("rstresp late data_data_ok", data_data_ok, 0);
      chk("rstresp late busy", busy, 0);
      nextCycle();
      bus_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
      grantQ.push_back(1'b0);
      sample();
      chk("rstresp regrant", inst_addr_ok, 1);
      nextCycle();
      inst_req = 1'b0; bus_addr_ok = 1'b1;
      sample();
      chk("rstresp bus_addr", bus_addr, 32'hBFC0_0100);
      nextCycle();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h4444_4444;
      respQ.push_back('{isData: 1'b0, rdata: 32'h4444_4444});
      sample();
      nextCycle();
      bus_data_ok = 1'b0;
      sample();
      chk("rstresp final busy", busy, 0);

      nextCycle();
      chk("grant queue drained", grantQ.size(), 0);
      chk("resp queue drained", respQ.size(), 0);

      checks   += monChecks;
      failures += monFails;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
